// File: rtl/pool_window_seq.sv
// pool_window_seq: multicycle window pooling unit (max or shift-average).
// One flattened window of WIN signed elements is taken per input handshake.
// LANES elements are then folded into an accumulator on each cycle, so
// STEPS = WIN/LANES cycles are needed per window. The result is held until
// downstream takes it.
//
// WIN must be a multiple of LANES.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; data_in and mode are captured on accept
//   mode                0 = max, 1 = average (sum >>> AVG_SHIFT, saturated)
//   data_in             element i at [i*DATA_W +: DATA_W], signed
//   out_valid/out_ready output handshake; data_out is valid while out_valid=1
//   data_out            signed pooled result, keeps its last value otherwise
//   busy                high while a window is being folded or held

// Per-lane element picker: selects element step*LANES+LANE_IDX of the
// buffered window and sign-extends it to the accumulator width.
module pool_lane #(
    parameter int DATA_W   = 8,
    parameter int WIN      = 9,
    parameter int LANES    = 3,
    parameter int LANE_IDX = 0,
    parameter int STEP_W   = 2,
    parameter int ACC_W    = 13
) (
    input  logic [WIN-1:0][DATA_W-1:0] win,
    input  logic [STEP_W-1:0]          step,
    output logic signed [ACC_W-1:0]    val
);
    localparam int IDX_W = (WIN > 1) ? $clog2(WIN) : 1;

    logic [IDX_W-1:0]         idx;
    logic signed [DATA_W-1:0] elem;

    assign idx  = IDX_W'(int'(step) * LANES + LANE_IDX);
    assign elem = win[idx];
    assign val  = ACC_W'(elem);
endmodule

module pool_window_seq #(
    parameter int DATA_W    = 8,
    parameter int WIN       = 9,
    parameter int LANES     = 3,
    parameter int AVG_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     mode,
    input  logic [WIN*DATA_W-1:0]    data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     busy
);
    localparam int STEPS  = WIN / LANES;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    // Sum of WIN elements of DATA_W bits plus a sign bit of headroom.
    localparam int ACC_W  = DATA_W + $clog2(WIN) + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN   = ~SAT_MAX;
    localparam logic [STEP_W-1:0]       LAST_STEP = STEP_W'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    typedef struct packed {
        logic                       avg;
        logic [WIN-1:0][DATA_W-1:0] elems;
    } win_req_t;

    state_t                        state, state_nxt;
    win_req_t                      req_q;
    logic [STEP_W-1:0]             step;
    logic signed [ACC_W-1:0]       acc, fold, shifted;
    logic signed [DATA_W-1:0]      final_val;
    logic [LANES-1:0][ACC_W-1:0]   lane_val;
    logic                          accept, last, xfer;

    assign accept   = in_valid && (state == IDLE);
    assign last     = (step == LAST_STEP);
    assign xfer     = out_valid && out_ready;
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pool_lane #(
            .DATA_W  (DATA_W),
            .WIN     (WIN),
            .LANES   (LANES),
            .LANE_IDX(g),
            .STEP_W  (STEP_W),
            .ACC_W   (ACC_W)
        ) u_lane (
            .win (req_q.elems),
            .step(step),
            .val (lane_val[g])
        );
    end

    // Fold this step's lanes into the running value. Ties in max mode keep
    // the earlier value, which is numerically identical anyway.
    always_comb begin
        fold = acc;
        for (int l = 0; l < LANES; l++) begin
            if (req_q.avg)
                fold = fold + $signed(lane_val[l]);
            else if ($signed(lane_val[l]) > fold)
                fold = $signed(lane_val[l]);
        end
    end

    // Arithmetic shift floors toward -inf; then clamp to the element range.
    assign shifted = fold >>> AVG_SHIFT;

    always_comb begin
        final_val = fold[DATA_W-1:0];
        if (req_q.avg) begin
            if (shifted > SAT_MAX)
                final_val = SAT_MAX[DATA_W-1:0];
            else if (shifted < SAT_MIN)
                final_val = SAT_MIN[DATA_W-1:0];
            else
                final_val = shifted[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = ACCUM;
            ACCUM:   if (last)      state_nxt = DONE;
            // out_valid is high for the whole of DONE.
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            step      <= '0;
            acc       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                req_q <= {mode, data_in};
                step  <= '0;
                acc   <= mode ? '0 : SAT_MIN;
            end
            if (state == ACCUM) begin
                acc <= fold;
                if (last) begin
                    data_out  <= final_val;
                    out_valid <= 1'b1;
                end else begin
                    step <= step + 1'b1;
                end
            end
            if (xfer) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pool_window_seq.sv
module tb_pool_window_seq;
    typedef int win9_t[9];
    typedef int win4_t[4];

    typedef struct {
        win9_t e;
        logic  m;
        int    hold;
        int    exp_a;
        int    exp_b;
        string name;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic              rst_n, in_valid, mode, out_ready;
    logic [71:0]       data_in;
    logic              in_ready_a, out_valid_a, busy_a;
    logic              in_ready_b, out_valid_b, busy_b;
    logic signed [7:0] data_out_a, data_out_b;

    logic              in_valid4, mode4, out_ready4;
    logic [31:0]       data_in4;
    logic              in_ready4, out_valid4, busy4;
    logic signed [7:0] data_out4;

    pool_window_seq u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .mode(mode), .data_in(data_in), .out_valid(out_valid_a),
        .out_ready(out_ready), .data_out(data_out_a), .busy(busy_a)
    );

    pool_window_seq #(.AVG_SHIFT(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .mode(mode), .data_in(data_in), .out_valid(out_valid_b),
        .out_ready(out_ready), .data_out(data_out_b), .busy(busy_b)
    );

    pool_window_seq #(.WIN(4), .LANES(2), .AVG_SHIFT(2)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .mode(mode4), .data_in(data_in4), .out_valid(out_valid4),
        .out_ready(out_ready4), .data_out(data_out4), .busy(busy4)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [71:0] pack9(input win9_t e);
        logic [71:0] p;
        p = '0;
        for (int i = 0; i < 9; i++) p[i*8 +: 8] = 8'(e[i]);
        return p;
    endfunction

    // Reference: max of the elements, or floor(sum / 2^shift) clamped to int8.
    function automatic int ref_pool(input logic [71:0] w, input int n, input logic m, input int shift);
        int v, acc, d, q;
        acc = m ? 0 : -1000000;
        for (int i = 0; i < n; i++) begin
            v = int'($signed(w[i*8 +: 8]));
            if (m) acc += v;
            else if (v > acc) acc = v;
        end
        if (!m) return acc;
        d = 1 << shift;
        q = acc / d;
        if ((acc % d != 0) && (acc < 0)) q--;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    task automatic add_vec(input win9_t e, input logic m, input int hold, input int ea, input int eb, input string nm);
        vec_t v;
        v.e = e; v.m = m; v.hold = hold; v.exp_a = ea; v.exp_b = eb; v.name = nm;
        vecs.push_back(v);
    endtask

    // Runs one window through u_dut and u_sat. Entered and left at a negedge.
    task automatic do_window(input win9_t e, input logic m, input int hold,
                             input int exp_a, input int exp_b, input string tag,
                             output int acc_cyc);
        int n;
        data_in   = pack9(e);
        mode      = m;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        n = 0;
        while (!in_ready_a && n < 50) begin @(negedge clk); n++; end
        check({tag, " in_ready"}, int'(in_ready_a), 1);
        @(posedge clk);
        acc_cyc = cyc_cnt;
        @(negedge clk);
        // Scramble inputs: must not affect the window in flight.
        in_valid = 1'b0;
        data_in  = 72'({$urandom, $urandom, $urandom});
        mode     = ~m;
        n = 0;
        while (!out_valid_a && n < 20) begin @(negedge clk); n++; end
        check({tag, " latency"}, n, 3);
        check({tag, " valid_b"}, int'(out_valid_b), 1);
        check({tag, " data_a"}, int'(data_out_a), exp_a);
        check({tag, " data_b"}, int'(data_out_b), exp_b);
        check({tag, " busy"}, int'(busy_a), 1);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check({tag, " hold valid"}, int'(out_valid_a), 1);
            check({tag, " hold data"}, int'(data_out_a), exp_a);
            check({tag, " hold in_ready"}, int'(in_ready_a), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, " post valid"}, int'(out_valid_a), 0);
        check({tag, " post in_ready"}, int'(in_ready_a), 1);
        check({tag, " post busy"}, int'(busy_a), 0);
    endtask

    task automatic do_w4(input win4_t e, input logic m, input int exp, input string tag);
        int n;
        for (int i = 0; i < 4; i++) data_in4[i*8 +: 8] = 8'(e[i]);
        mode4      = m;
        in_valid4  = 1'b1;
        out_ready4 = 1'b1;
        n = 0;
        while (!in_ready4 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 1'b0;
        data_in4  = $urandom;
        mode4     = ~m;
        n = 0;
        while (!out_valid4 && n < 20) begin @(negedge clk); n++; end
        check({tag, " latency"}, n, 2);
        check({tag, " data"}, int'(data_out4), exp);
        @(negedge clk);
        check({tag, " post valid"}, int'(out_valid4), 0);
        check({tag, " post in_ready"}, int'(in_ready4), 1);
    endtask

    initial begin
        int    t [$];
        int    tc, bad, ea, eb;
        win9_t e;
        win4_t e4;
        logic  m;
        logic [71:0] w;

        add_vec('{-3, 7, -128, 127, 0, 5, -1, 2, 6}, 1'b0, 0, 127, 127, "max_mix");
        add_vec('{-128, -128, -128, -128, -128, -128, -128, -128, -128}, 1'b0, 0, -128, -128, "max_min");
        add_vec('{127, 127, 127, 127, 127, 127, 127, 127, 127}, 1'b0, 0, 127, 127, "max_max");
        add_vec('{100, 100, 100, 100, 100, 100, 100, 100, 100}, 1'b1, 0, 112, 127, "avg_pos_sat");
        add_vec('{-128, -128, -128, -128, -128, -128, -128, -128, -128}, 1'b1, 0, -128, -128, "avg_neg_sat");
        add_vec('{1, 2, 3, 4, 5, 6, 7, 8, 9}, 1'b1, 0, 5, 45, "avg_small");
        add_vec('{-1, -2, -3, -4, -5, -6, -7, -8, -9}, 1'b1, 0, -6, -45, "avg_floor");
        add_vec('{1, 2, 3, 4, 5, 6, 7, 8, 9}, 1'b0, 5, 9, 9, "max_backpressure");
        add_vec('{4, -9, 4, 4, -9, 4, 0, 4, -9}, 1'b0, 2, 4, 4, "max_ties");

        rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b0; data_in = '0;
        in_valid4 = 1'b0; mode4 = 1'b0; out_ready4 = 1'b0; data_in4 = '0;
        repeat (2) @(negedge clk);
        check("rst out_valid", int'(out_valid_a), 0);
        check("rst in_ready", int'(in_ready_a), 1);
        check("rst busy", int'(busy_a), 0);
        check("rst data_out", int'(data_out_a), 0);
        check("rst in_ready_b", int'(in_ready_b), 1);
        check("rst busy_b", int'(busy_b), 0);
        check("rst busy4", int'(busy4), 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_window(vecs[i].e, vecs[i].m, vecs[i].hold, vecs[i].exp_a, vecs[i].exp_b, vecs[i].name, tc);
            t.push_back(tc);
        end
        // max_min and max_max run with no idle gap: accept-to-accept = STEPS+2.
        check("b2b interval", t[2] - t[1], 5);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 9; i++) e[i] = int'($urandom_range(0, 255)) - 128;
            m  = 1'($urandom_range(0, 1));
            w  = pack9(e);
            ea = ref_pool(w, 9, m, 3);
            eb = ref_pool(w, 9, m, 0);
            do_window(e, m, int'($urandom_range(0, 2)), ea, eb, "rand", tc);
        end

        do_w4('{10, 20, 30, 41}, 1'b1, 25, "w4 avg");
        do_w4('{-1, -2, -3, -4}, 1'b1, -3, "w4 avg_floor");
        do_w4('{10, -20, 30, -41}, 1'b0, 30, "w4 max");
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 4; i++) e4[i] = int'($urandom_range(0, 255)) - 128;
            m = 1'($urandom_range(0, 1));
            w = '0;
            for (int i = 0; i < 4; i++) w[i*8 +: 8] = 8'(e4[i]);
            do_w4(e4, m, ref_pool(w, 4, m, 2), "w4 rand");
        end

        // Reset in the middle of ACCUM: nothing from that window may appear.
        data_in   = pack9('{100, 100, 100, 100, 100, 100, 100, 100, 100});
        mode      = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", int'(out_valid_a), 0);
        check("mid rst in_ready", int'(in_ready_a), 1);
        check("mid rst busy", int'(busy_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid_a || out_valid_b) bad++;
        end
        check("no stale result", bad, 0);
        do_window('{1, 2, 3, 4, 5, 6, 7, 8, 9}, 1'b0, 0, 9, 9, "post_rst", tc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pool_window_seq.md
Name: pool_window_seq

Overview:
- Parametrised multicycle window pooling unit for the DNN accelerator datapath; successor to the fixed 3x3 max-pool stage.
- Accepts one flattened window of WIN signed elements per handshake and folds LANES elements per cycle into an accumulator.
- Supports a per-window mode: max or shift-average.
- Uses valid/ready on both sides, so it can sit between the line-buffer window generator and the activation writeback stage with backpressure.

Parameters:
- DATA_W, 8, signed element and result width.
- WIN, 9, elements per window (flattened KxK); must be a multiple of LANES.
- LANES, 3, elements folded per ACCUM cycle; STEPS = WIN/LANES.
- AVG_SHIFT, 3, arithmetic right shift applied to the window sum in average mode.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  window on data_in is valid.
- in_ready  out  1  block can accept a window.
- mode  in  1  0 = max, 1 = average; sampled with the window.
- data_in  in  WIN*DATA_W  element i at bits [i*DATA_W +: DATA_W], signed.
- out_valid  out  1  data_out holds a result.
- out_ready  in  1  downstream accepts the result.
- data_out  out  DATA_W  signed pooled result.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Reset (async, rst_n low): state=IDLE, in_ready=1, out_valid=0, data_out=0, busy=0, step counter=0, accumulator=0. Any window in flight is discarded; no partial result is ever emitted.
- States: IDLE, ACCUM, DONE. in_ready = (state==IDLE); busy = !IDLE.
- IDLE:
  - On in_valid && in_ready, register all of data_in and mode into the internal window buffer.
  - Accumulator init: max mode = -2^(DATA_W-1); avg mode = 0. step=0.
  - Go to ACCUM.
- ACCUM:
  - Each cycle fold elements [step*LANES .. step*LANES+LANES-1] of the buffered window into the accumulator.
  - Max mode: signed compare; result is the running maximum.
  - Avg mode: signed add; accumulator width DATA_W+$clog2(WIN)+1, which never overflows.
  - On the fold with step==STEPS-1, compute the final value from the accumulator plus the last lanes. Register it into data_out, set out_valid=1, go to DONE. Otherwise step++.
- Avg finalisation: sum >>> AVG_SHIFT (floor toward -inf), then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Max finalisation: no shift, no saturation.
- Latency: out_valid is high after exactly STEPS rising edges following the accept edge. With WIN=9, LANES=3: accept at edge 0, out_valid high after edge 3.
- DONE:
  - Hold data_out and out_valid stable while out_ready=0.
  - On out_valid && out_ready, clear out_valid and go to IDLE. in_ready is high the following cycle.
  - Minimum accept-to-accept interval is STEPS+2 cycles.
- data_in and mode changes after the accept edge have no effect on the current window.
- in_valid while not ready is ignored; the source must hold it.
- out_ready while out_valid=0 has no effect.
- Equal elements in max mode: the value is the same regardless of which element wins.
- data_out keeps its last value in IDLE and ACCUM. Only out_valid qualifies it.

Test Plan:
- Max mode, defaults, window {-3,7,-128,127,0,5,-1,2,6}, out_ready=1 -> out_valid high 3 edges after accept, data_out=127, one-cycle pulse, in_ready back high next cycle.
- Max mode, all nine elements = -128 -> data_out=-128. Then all = 127 -> data_out=127, with back-to-back windows separated by STEPS+2 cycles.
- Avg mode, WIN=4, LANES=2, AVG_SHIFT=2: {10,20,30,41} -> 25. Then {-1,-2,-3,-4} -> -3 (floor of -2.5).
- Avg saturation, defaults with AVG_SHIFT=0: all elements 100 (sum 900) -> 127. All elements -128 (sum -1152) -> -128.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> data_out and out_valid stable, in_ready=0, busy=1, and a new in_valid is not accepted. Release -> transfer on that edge, IDLE next cycle. Change data_in/mode during ACCUM -> result unaffected.
- Reset during ACCUM (after edge 1 of 3) -> out_valid=0, in_ready=1, busy=0 immediately. A new window {1,2,3,4,5,6,7,8,9} max -> 9, no stale result emitted.
